// File: rtl/dpr_pkg.sv
// Shared defaults for the dual-port-RAM FIFO slice: data/address widths, depth and almost-full threshold.
package dpr_pkg;

    localparam int unsigned DEF_DATA_W    = 16;
    localparam int unsigned DEF_ADDR_W    = 10;
    localparam int unsigned DEPTH         = 2**DEF_ADDR_W;
    localparam int unsigned DEF_AFULL_THR = 1020;

endpackage

// File: rtl/dpr_ptr.sv
// Wrapping pointer: W-bit counter whose MSB acts as the wrap bit; advances by one when inc is high.
module dpr_ptr
    import dpr_pkg::*;
#(
    parameter int unsigned W = DEF_ADDR_W + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/dpr_fifo_ctrl.sv
// FIFO controller driving a synchronous dual-port RAM: turns push/pop into RAM strobes,
// tracks occupancy and flags, and returns read data aligned to the RAM's 1-cycle latency.
module dpr_fifo_ctrl
    import dpr_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned AFULL_THR = DEF_AFULL_THR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    output logic              ram_wr_en,
    output logic              ram_rd_en,
    output logic              ram_blk_sel,
    output logic [ADDR_W-1:0] ram_addr_wr,
    output logic [ADDR_W-1:0] ram_addr_rd,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int unsigned PTR_W      = ADDR_W + 1;
    localparam int unsigned FIFO_DEPTH = 2**ADDR_W;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             acc_push_c;
    logic             acc_pop_c;
    logic             unused_wrap;

    // Acceptance; qualifying with rst keeps every RAM strobe low while reset is held.
    assign acc_push_c = rst & push & ~full;
    assign acc_pop_c  = rst & pop & ~empty;

    assign ram_wr_en   = acc_push_c;
    assign ram_rd_en   = acc_pop_c;
    assign ram_blk_sel = acc_push_c | acc_pop_c;
    assign ram_din     = push_data;
    assign pop_data    = ram_dout;

    dpr_ptr #(.W(PTR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (acc_push_c),
        .ptr (wr_ptr)
    );

    dpr_ptr #(.W(PTR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (acc_pop_c),
        .ptr (rd_ptr)
    );

    assign ram_addr_wr = wr_ptr[ADDR_W-1:0];
    assign ram_addr_rd = rd_ptr[ADDR_W-1:0];
    // Wrap bits are not needed for the flags (those come from count); kept for debug visibility.
    assign unused_wrap = wr_ptr[ADDR_W] ^ rd_ptr[ADDR_W];

    // Flags are decoded from the registered count.
    assign full        = (count == PTR_W'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign almost_full = (count >= PTR_W'(AFULL_THR));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (acc_push_c && !acc_pop_c) begin
            count <= count + PTR_W'(1);
        end else if (!acc_push_c && acc_pop_c) begin
            count <= count - PTR_W'(1);
        end
    end

    // Read-data valid tracks the RAM latency; the error flags are sticky until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pop_valid <= acc_pop_c;
            overflow  <= overflow | (push & full);
            underflow <= underflow | (pop & empty);
        end
    end

endmodule
